// File: rtl/alu_result_buffer.sv
// In-order result FIFO between the 8-bit ALU and its consumer.
// Optional statistics counters enabled by defining ALU_BUF_STATS_EN.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 result,
  input  logic                       carry_out,
  input  logic [3:0]                 op_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [3:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop_err,
  input  logic                       clear
`ifdef ALU_BUF_STATS_EN
  ,
  output logic [CNT_W-1:0]           accept_cnt,
  output logic [CNT_W-1:0]           carry_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic [3:0] op;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   hd_ptr;
  logic            push;
  logic            pop;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // When empty, rd_ptr-1 is the slot last popped, so outputs hold it.
  assign hd_ptr    = out_valid ? rd_ptr : rd_ptr - AW'(1);
  assign head      = mem[hd_ptr];
  assign out_data  = head.data;
  assign out_carry = head.carry;
  assign out_zero  = head.zero;
  assign out_op    = head.op;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{result, carry_out, result == 8'h00, op_code};
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     drop_err <= 1'b0;
    else if (in_valid && !in_ready) drop_err <= 1'b1;
    else if (clear)                 drop_err <= 1'b0;
  end

`ifdef ALU_BUF_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accept_cnt <= '0;
      carry_cnt  <= '0;
    end else if (clear) begin
      accept_cnt <= '0;
      carry_cnt  <= '0;
    end else if (push) begin
      if (!(&accept_cnt))
        accept_cnt <= accept_cnt + CNT_W'(1);
      if (carry_out && !(&carry_cnt))
        carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer against a queue-based model.
// Stats checks compile in only when ALU_BUF_STATS_EN is defined.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic [3:0] op;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result;
  logic       carry_out;
  logic [3:0] op_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;
  logic [3:0] out_op;
  logic [2:0] count;
  logic       drop_err;
  logic       clear;
`ifdef ALU_BUF_STATS_EN
  logic [CNT_W-1:0] accept_cnt;
  logic [CNT_W-1:0] carry_cnt;
  int               m_acc;
  int               m_cry;
`endif

  exp_t       sb[$];
  int         mcnt;
  bit         mdrop;
  int         n_cmp;
  int         n_bad;
  bit         have_last;
  logic [7:0] last_data;

  alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .carry_out(carry_out), .op_code(op_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry),
    .out_zero(out_zero), .out_op(out_op),
    .count(count), .drop_err(drop_err), .clear(clear)
`ifdef ALU_BUF_STATS_EN
    , .accept_cnt(accept_cnt), .carry_cnt(carry_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over an entry.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_carry", out_carry, e.carry);
        chk("out_zero", out_zero, e.zero);
        chk("out_op", out_op, e.op);
        have_last = 1'b1;
        last_data = e.data;
      end
    end
  end

  // Called at posedge+1: checks model state, drives one cycle, updates model.
  task automatic step(input bit iv, input logic [7:0] r, input bit c,
                      input logic [3:0] op, input bit ordy, input bit clr);
    bit p;
    bit q;
    chk("count", count, mcnt);
    chk("in_ready", in_ready, mcnt < DEPTH);
    chk("out_valid", out_valid, mcnt != 0);
    chk("drop_err", drop_err, mdrop);
`ifdef ALU_BUF_STATS_EN
    chk("accept_cnt", accept_cnt, m_acc);
    chk("carry_cnt", carry_cnt, m_cry);
`endif
    in_valid  = iv;
    result    = r;
    carry_out = c;
    op_code   = op;
    out_ready = ordy;
    clear     = clr;
    p = iv && (mcnt < DEPTH);
    q = (mcnt != 0) && ordy;
    if (p) sb.push_back('{r, c, r == 8'h00, op});
    @(posedge clock);
    #1;
    mcnt = mcnt + int'(p) - int'(q);
    if (clr) mdrop = 1'b0;
    if (iv && !p) mdrop = 1'b1;
`ifdef ALU_BUF_STATS_EN
    if (clr) begin
      m_acc = 0;
      m_cry = 0;
    end else if (p) begin
      if (m_acc < (1 << CNT_W) - 1) m_acc++;
      if (c && m_cry < (1 << CNT_W) - 1) m_cry++;
    end
`endif
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 8'h00, 1'b0, 4'h0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mcnt > 0; i++) idle(1'b1);
    chk("drained", mcnt, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mcnt = 0; mdrop = 0; have_last = 0;
`ifdef ALU_BUF_STATS_EN
    m_acc = 0; m_cry = 0;
`endif
    reset = 1'b0; in_valid = 0; result = 0; carry_out = 0;
    op_code = 0; out_ready = 0; clear = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_op", out_op, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // single entry
    step(1'b1, 8'hFF, 1'b1, 4'h2, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("hold_after_empty", out_data, 8'hFF);

    // fill, overflow, pop-only when full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 8'h10 + 8'(i), i[0], 4'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 4'hE, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 4'hD, 1'b1, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 4'hC, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // at count 2: push and pop together
    step(1'b1, 8'h5A, 1'b1, 4'h5, 1'b1, 1'b0);
    drain();

    // zero/wrap stream
    for (int v = 0; v <= 5; v++) begin
      bit sent;
      sent = 0;
      for (int t = 0; t < 10 && !sent; t++) begin
        sent = mcnt < DEPTH;
        step(sent, 8'(v), 1'b0, 4'(v), 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    drain();

    // reset with entries queued
    step(1'b1, 8'h11, 1'b0, 4'h1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b1, 4'h2, 1'b0, 1'b0);
    in_valid = 1'b1;
    step(1'b1, 8'h33, 1'b0, 4'h3, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_drop", drop_err, 0);
    sb.delete();
    mcnt = 0; mdrop = 0;
`ifdef ALU_BUF_STATS_EN
    m_acc = 0; m_cry = 0;
`endif
    in_valid = 0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

`ifdef ALU_BUF_STATS_EN
    step(1'b1, 8'h01, 1'b1, 4'h1, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b0, 4'h1, 1'b1, 1'b0);
    step(1'b1, 8'h03, 1'b1, 4'h1, 1'b1, 1'b0);
    chk("stats_acc3", accept_cnt, 3);
    chk("stats_cry2", carry_cnt, 2);
    step(1'b1, 8'h04, 1'b1, 4'h1, 1'b1, 1'b1);
    chk("stats_clr_acc", accept_cnt, 0);
    drain();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 9) < 7, r, 1'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
    end
    drain();
    idle(1'b0);
    if (have_last) chk("final_hold", out_data, last_data);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
